int_arbiter: RTL and testbench
==============================

// Module: int_arbiter
// PURPOSE
//   Multi-source interrupt controller in front of the jump-control block's single 1-bit interrupt input.
//   Edge-detects up to N_SRC requesters and latches them as pending.
//   Applies a per-source mask and a global enable, then picks one winner by fixed priority.
//   Issues a one-cycle interrupt pulse and holds off further interrupts until the handler's RET retires.
//   Non-nesting: at most one interrupt in service.
// PARAMETERS
//   N_SRC     4        number of interrupt sources (1..16)
//   ID_W      2        width of int_id; must equal clog2(N_SRC), minimum 1
//   GUARD_CYC 2        cycles after the pulse before RET is honoured (pipeline refill of vector fetch)
//   RET_OP    6'h10    opcode decoded as RET (matches jump-control decode 010000)
// PORTS
//   clk         in   1      system clock, all state on posedge
//   reset       in   1      synchronous, active-high; clears all state
//   irq_in      in   N_SRC  raw requests, rising edge = request
//   mask_we     in   1      write strobe for mask register
//   mask_wdata  in   N_SRC  new mask value, 1 = source masked
//   int_en      in   1      global interrupt enable
//   op          in   6      opcode of instruction at jump-control stage
//   pc_mux_sel  in   1      jump-control redirect in this cycle (branch/jmp/ret taken)
//   interrupt   out  1      to jump-control interrupt input, registered, 1-cycle pulse
//   int_id      out  ID_W   index of source currently/last serviced
//   in_service  out  1      high from pulse until RET accepted
//   pending     out  N_SRC  latched pending requests (status)
//   mask        out  N_SRC  current mask register (status)
// BEHAVIOUR
//   Reset (reset=1 at posedge):
//     state=IDLE; interrupt=0; in_service=0; int_id=0; pending=0; mask=all 1s; irq_prev=0; guard count=0.
//     A source already high on the first cycle after reset counts as a rising edge.
//   Edge detection: irq_prev<=irq_in every cycle; edge[i] = irq_in[i] & ~irq_prev[i].
//     Pending[i] is set at the posedge where edge[i]=1, in all states and regardless of mask.
//   Mask: mask_we=1 loads mask_wdata at the posedge; the new mask affects eligibility from the next cycle.
//   Eligibility: elig = pending & ~mask. Winner = lowest index set in elig (index 0 = highest priority).
//   FSM states:
//     IDLE:
//       Goes to FIRE when (|elig) & int_en & ~pc_mux_sel.
//       pc_mux_sel=1 blocks firing, so the saved return address is never a discarded fall-through.
//       On the transition edge: interrupt<=1, int_id<=winner, pending[winner]<=0, in_service<=1.
//     FIRE (1 cycle): interrupt<=0; guard count<=GUARD_CYC; go to GUARD.
//     GUARD: decrement each cycle; op is ignored; at count==0 go to SERVICE.
//     SERVICE: op==RET_OP goes to IDLE with in_service<=0; otherwise stays.
//   Latency: irq rise sampled at posedge t -> pending at t -> interrupt high after posedge t+1, if eligible and unblocked.
//   Simultaneous events:
//     New edge on the winner in the cycle it is taken: pending stays 1 (set beats clear).
//     Mask write in the same cycle as IDLE->FIRE: decision uses the old mask.
//     int_en dropping after FIRE does not cancel the service in progress.
//   Masked or disabled sources stay pending indefinitely and fire once eligible.
//   Reset mid-service: the FSM returns to IDLE and all pending are lost.
//   interrupt is never high for 2 consecutive cycles.
//   At most 1 pulse between consecutive RET acceptances.
// TESTING
//   Single request: mask=0, int_en=1, irq_in[2] rises -> interrupt pulses exactly 1 cycle, 2 cycles later.
//     Expect int_id=2, pending[2]=0, in_service=1 until op=6'h10 in SERVICE.
//   Priority: irq_in[3] and irq_in[1] rise together -> first pulse int_id=1; after RET, second pulse int_id=3.
//     No pulse while in_service=1.
//   Masking: mask=4'b0001, irq_in[0] rises -> no pulse, pending=4'b0001.
//     Write mask=0 -> pulse with int_id=0 one cycle after the write edge.
//   Branch block: eligible request while pc_mux_sel=1 for 3 cycles -> interrupt stays 0.
//     Pulse occurs the cycle after pc_mux_sel falls.
//   Guard/RET: op=6'h10 during GUARD is ignored (in_service stays 1).
//     op=6'h10 in SERVICE clears in_service next edge.
//   Reset mid-service: assert reset in SERVICE with pending=4'b1000 -> next cycle all outputs at reset values.
//     mask=4'b1111, no spurious pulse.

Source files
------------

// File: rtl/int_arbiter.sv
// int_arbiter: edge-triggered, masked, fixed-priority interrupt controller that
// feeds a single 1-bit interrupt line. It is non-nesting: only one interrupt can
// be in service at a time, and service ends when the handler's RET is accepted.
module int_arbiter #(
  parameter int          N_SRC     = 4,
  parameter int          ID_W      = 2,
  parameter int          GUARD_CYC = 2,
  parameter logic [5:0]  RET_OP    = 6'h10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             int_en,
  input  logic [5:0]       op,
  input  logic             pc_mux_sel,
  output logic             interrupt,
  output logic [ID_W-1:0]  int_id,
  output logic             in_service,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] mask
);

  localparam int GW = (GUARD_CYC < 1) ? 1 : $clog2(GUARD_CYC + 1);

  typedef enum logic [1:0] {IDLE, FIRE, GUARD, SERVICE} state_t;

  state_t           state_q;
  logic [GW-1:0]    cnt_q;
  logic [N_SRC-1:0] irq_prev_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q;
  logic             interrupt_q;
  logic [ID_W-1:0]  int_id_q;
  logic             in_service_q;

  logic [N_SRC-1:0] rise, elig, win_oh;
  logic [ID_W-1:0]  winner;
  logic             fire;

  // Edge detect, eligibility, and lowest-index winner. Set beats clear on pending,
  // so a new edge on the winner in its take cycle stays pending.
  always_comb begin
    rise   = irq_in & ~irq_prev_q;
    elig   = pending_q & ~mask_q;
    win_oh = elig & (~elig + N_SRC'(1));
    winner = '0;
    for (int i = 0; i < N_SRC; i++)
      if (win_oh[i]) winner = ID_W'(i);
    // A redirect this cycle blocks firing so the saved return address is real.
    fire      = (state_q == IDLE) && (|elig) && int_en && !pc_mux_sel;
    pending_d = (pending_q & ~(fire ? win_oh : '0)) | rise;
  end

  // Status registers: request history, pending latch, mask.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '1;
    end else begin
      irq_prev_q <= irq_in;
      pending_q  <= pending_d;
      if (mask_we) mask_q <= mask_wdata;
    end
  end

  // Service FSM with registered outputs; GUARD ignores op while the vector fetch refills.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      interrupt_q  <= 1'b0;
      int_id_q     <= '0;
      in_service_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          interrupt_q <= 1'b0;
          if (fire) begin
            state_q      <= FIRE;
            interrupt_q  <= 1'b1;
            int_id_q     <= winner;
            in_service_q <= 1'b1;
          end
        end
        FIRE: begin
          interrupt_q <= 1'b0;
          cnt_q       <= GW'(GUARD_CYC);
          state_q     <= GUARD;
        end
        GUARD: begin
          if (cnt_q == '0) state_q <= SERVICE;
          else             cnt_q   <= cnt_q - GW'(1);
        end
        SERVICE: begin
          if (op == RET_OP) begin
            state_q      <= IDLE;
            in_service_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign interrupt  = interrupt_q;
  assign int_id     = int_id_q;
  assign in_service = in_service_q;
  assign pending    = pending_q;
  assign mask       = mask_q;

endmodule

// File: tb/tb_int_arbiter.sv
// Bench for int_arbiter: directed vector table, hand-written corner sequences,
// then random traffic, all compared against a cycle-level behavioural model.
module tb_int_arbiter;

  localparam int         N   = 4;
  localparam int         GC  = 2;
  localparam logic [5:0] RET = 6'h10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] irq_in = '0;
  logic       mask_we = 1'b0;
  logic [3:0] mask_wdata = '0;
  logic       int_en = 1'b0;
  logic [5:0] op = '0;
  logic       pc_mux_sel = 1'b0;
  logic       interrupt;
  logic [1:0] int_id;
  logic       in_service;
  logic [3:0] pending;
  logic [3:0] mask;

  int checks = 0;
  int errors = 0;

  int_arbiter #(.N_SRC(N), .ID_W(2), .GUARD_CYC(GC), .RET_OP(RET)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .int_en(int_en), .op(op), .pc_mux_sel(pc_mux_sel),
    .interrupt(interrupt), .int_id(int_id), .in_service(in_service),
    .pending(pending), .mask(mask)
  );

  always #5 clk = ~clk;

  // Reference model: in service iff busy; RET honoured once GC+2 cycles have
  // passed since the pulse (pulse, FIRE->GUARD, GC+1 guard cycles).
  logic [3:0] m_pend = '0, m_mask = '1, m_prev = '0;
  logic       m_int = 1'b0, m_busy = 1'b0, prev_int = 1'b0;
  logic [1:0] m_id = '0;
  int         m_age = 0;

  task automatic model_step();
    logic [3:0] rs, el;
    int w;
    if (reset) begin
      m_pend = '0; m_mask = '1; m_prev = '0; m_int = 1'b0;
      m_busy = 1'b0; m_id = '0; m_age = 0;
    end else begin
      rs = irq_in & ~m_prev;
      el = m_pend & ~m_mask;
      m_int = 1'b0;
      if (!m_busy && el != 0 && int_en && !pc_mux_sel) begin
        w = 0;
        for (int i = N-1; i >= 0; i--) if (el[i]) w = i;
        m_pend[w] = 1'b0;
        m_id = 2'(w);
        m_int = 1'b1;
        m_busy = 1'b1;
        m_age = 0;
      end else if (m_busy && m_age >= GC + 2 && op == RET) begin
        m_busy = 1'b0;
      end else if (m_busy) begin
        m_age++;
      end
      m_pend = m_pend | rs;
      if (mask_we) m_mask = mask_wdata;
      m_prev = irq_in;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: advance model, clock DUT, compare every output after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("interrupt", 32'(interrupt), 32'(m_int));
    chk("int_id", 32'(int_id), 32'(m_id));
    chk("in_service", 32'(in_service), 32'(m_busy));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("mask", 32'(mask), 32'(m_mask));
    chk("no_back_to_back", 32'(interrupt & prev_int), 32'd0);
    prev_int = interrupt;
  endtask

  task automatic idle_in();
    irq_in = '0; mask_we = 1'b0; mask_wdata = '0; op = '0; pc_mux_sel = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  typedef struct packed {
    logic [3:0] irq; logic mwe; logic [3:0] mwd; logic en; logic [5:0] op; logic pcs;
    logic e_int; logic [1:0] e_id; logic e_svc; logic [3:0] e_pend; logic [3:0] e_mask;
  } vec_t;

  vec_t tbl [16];

  initial begin
    // Expected outputs are those after the edge that samples the row's inputs.
    tbl[0]  = '{4'h0, 1'b1, 4'h0, 1'b1, 6'h00, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0};
    tbl[1]  = '{4'h4, 1'b0, 4'h0, 1'b1, 6'h00, 1'b0, 1'b0, 2'd0, 1'b0, 4'h4, 4'h0};
    tbl[2]  = '{4'h4, 1'b0, 4'h0, 1'b1, 6'h00, 1'b0, 1'b1, 2'd2, 1'b1, 4'h0, 4'h0};
    tbl[3]  = '{4'h4, 1'b0, 4'h0, 1'b1, RET,   1'b0, 1'b0, 2'd2, 1'b1, 4'h0, 4'h0};
    tbl[4]  = '{4'h4, 1'b0, 4'h0, 1'b1, RET,   1'b0, 1'b0, 2'd2, 1'b1, 4'h0, 4'h0};
    tbl[5]  = '{4'h4, 1'b0, 4'h0, 1'b1, RET,   1'b0, 1'b0, 2'd2, 1'b1, 4'h0, 4'h0};
    tbl[6]  = '{4'h4, 1'b0, 4'h0, 1'b1, RET,   1'b0, 1'b0, 2'd2, 1'b1, 4'h0, 4'h0};
    tbl[7]  = '{4'h4, 1'b0, 4'h0, 1'b1, RET,   1'b0, 1'b0, 2'd2, 1'b0, 4'h0, 4'h0};
    tbl[8]  = '{4'hA, 1'b0, 4'h0, 1'b1, 6'h00, 1'b0, 1'b0, 2'd2, 1'b0, 4'hA, 4'h0};
    tbl[9]  = '{4'hA, 1'b0, 4'h0, 1'b1, 6'h00, 1'b0, 1'b1, 2'd1, 1'b1, 4'h8, 4'h0};
    tbl[10] = '{4'h0, 1'b0, 4'h0, 1'b1, 6'h00, 1'b0, 1'b0, 2'd1, 1'b1, 4'h8, 4'h0};
    tbl[11] = '{4'h0, 1'b0, 4'h0, 1'b1, 6'h00, 1'b0, 1'b0, 2'd1, 1'b1, 4'h8, 4'h0};
    tbl[12] = '{4'h0, 1'b0, 4'h0, 1'b1, 6'h00, 1'b0, 1'b0, 2'd1, 1'b1, 4'h8, 4'h0};
    tbl[13] = '{4'h0, 1'b0, 4'h0, 1'b1, 6'h00, 1'b0, 1'b0, 2'd1, 1'b1, 4'h8, 4'h0};
    tbl[14] = '{4'h0, 1'b0, 4'h0, 1'b1, RET,   1'b0, 1'b0, 2'd1, 1'b0, 4'h8, 4'h0};
    tbl[15] = '{4'h0, 1'b0, 4'h0, 1'b1, 6'h00, 1'b0, 1'b1, 2'd3, 1'b1, 4'h0, 4'h0};

    // Reset state
    do_reset();
    chk("rst_interrupt", 32'(interrupt), 32'd0);
    chk("rst_in_service", 32'(in_service), 32'd0);
    chk("rst_int_id", 32'(int_id), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_mask", 32'(mask), 32'hF);

    // Single request, guard/RET, and priority via the vector table
    for (int k = 0; k < 16; k++) begin
      irq_in = tbl[k].irq; mask_we = tbl[k].mwe; mask_wdata = tbl[k].mwd;
      int_en = tbl[k].en; op = tbl[k].op; pc_mux_sel = tbl[k].pcs;
      tick();
      chk($sformatf("tbl%0d_int", k), 32'(interrupt), 32'(tbl[k].e_int));
      chk($sformatf("tbl%0d_id", k), 32'(int_id), 32'(tbl[k].e_id));
      chk($sformatf("tbl%0d_svc", k), 32'(in_service), 32'(tbl[k].e_svc));
      chk($sformatf("tbl%0d_pend", k), 32'(pending), 32'(tbl[k].e_pend));
      chk($sformatf("tbl%0d_mask", k), 32'(mask), 32'(tbl[k].e_mask));
    end

    // Masking: masked source stays pending, fires one cycle after unmask edge
    do_reset();
    int_en = 1'b1; mask_we = 1'b1; mask_wdata = 4'b0001; tick();
    mask_we = 1'b0; irq_in = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mask_hold_int", 32'(interrupt), 32'd0);
      chk("mask_hold_pend", 32'(pending), 32'h1);
    end
    mask_we = 1'b1; mask_wdata = 4'b0000; tick();
    chk("unmask_edge_int", 32'(interrupt), 32'd0);
    mask_we = 1'b0; tick();
    chk("unmask_fire_int", 32'(interrupt), 32'd1);
    chk("unmask_fire_id", 32'(int_id), 32'd0);

    // Branch block: redirect holds off an eligible request
    do_reset();
    int_en = 1'b1; mask_we = 1'b1; mask_wdata = 4'b0000; tick();
    mask_we = 1'b0; irq_in = 4'b0010; pc_mux_sel = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("branch_block_int", 32'(interrupt), 32'd0);
    end
    pc_mux_sel = 1'b0; tick();
    chk("branch_release_int", 32'(interrupt), 32'd1);
    chk("branch_release_id", 32'(int_id), 32'd1);

    // Reset mid-service with a queued request; source held high through reset
    do_reset();
    int_en = 1'b1; mask_we = 1'b1; mask_wdata = 4'b0000; tick();
    mask_we = 1'b0; irq_in = 4'b0001; tick(); tick();
    irq_in = 4'b1001; tick();
    irq_in = 4'b1000;
    for (int k = 0; k < 5; k++) tick();
    chk("pre_reset_svc", 32'(in_service), 32'd1);
    chk("pre_reset_pend", 32'(pending), 32'h8);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midrst_int", 32'(interrupt), 32'd0);
    chk("midrst_svc", 32'(in_service), 32'd0);
    chk("midrst_id", 32'(int_id), 32'd0);
    chk("midrst_pend", 32'(pending), 32'd0);
    chk("midrst_mask", 32'(mask), 32'hF);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_no_pulse", 32'(interrupt), 32'd0);
    end
    chk("post_rst_edge_pend", 32'(pending), 32'h8);

    // Random traffic against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      reset      = ($urandom_range(0, 199) == 0);
      irq_in     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : irq_in;
      mask_we    = ($urandom_range(0, 15) == 0);
      mask_wdata = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      int_en     = ($urandom_range(0, 7) != 0);
      op         = ($urandom_range(0, 2) == 0) ? RET : 6'($urandom);
      pc_mux_sel = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
